// File: rtl/mp_add_sequencer_if.sv
// Operand/result handshake bundle for the multi-precision add/subtract sequencer.
// master = operand source and result consumer, slave = sequencer.
interface mp_add_sequencer_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             c_out;
   logic             overflow;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, result, c_out, overflow
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, result, c_out, overflow
   );
endinterface

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract: one shared 16-bit prefix adder walks the operands
// LSB slice first, chaining the carry through a register between passes.
module mp_add_sequencer #(
   parameter int WIDTH = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   mp_add_sequencer_if.slave  bus
);
   localparam int NUM_SLICES = WIDTH / 16;
   localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             carry_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] result_q;
   logic             c_out_q;
   logic             overflow_q;

   logic [15:0]      a_slice;
   logic [15:0]      b_slice;
   logic [16:0]      add_p0;
   logic             accept;

   // Kogge-Stone prefix adder: log2(16) levels of group generate/propagate.
   function automatic logic [16:0] prefix_add16(input logic [15:0] x,
                                                input logic [15:0] y,
                                                input logic        ci);
      logic [15:0] g, p, gp, pp, gn, pn;
      logic [16:0] c;
      g  = x & y;
      p  = x ^ y;
      gp = g;
      pp = p;
      for (int lvl = 0; lvl < 4; lvl++) begin
         gn = gp;
         pn = pp;
         for (int i = (1 << lvl); i < 16; i++) begin
            gn[i] = gp[i] | (pp[i] & gp[i - (1 << lvl)]);
            pn[i] = pp[i] & pp[i - (1 << lvl)];
         end
         gp = gn;
         pp = pn;
      end
      c[0] = ci;
      for (int i = 0; i < 16; i++) c[i+1] = gp[i] | (pp[i] & ci);
      return {c[16], p ^ c[15:0]};
   endfunction

   assign accept  = (state == IDLE) && bus.in_valid && in_ready_q;
   assign a_slice = a_q[16*cnt +: 16];
   assign b_slice = b_q[16*cnt +: 16];
   assign add_p0  = prefix_add16(a_slice, b_slice, carry_q);

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.c_out     = c_out_q;
   assign bus.overflow  = overflow_q;

   // Operand capture: subtraction is folded in as A + ~B + 1 (carry seeded with sub).
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q <= bus.a;
         b_q <= bus.b ^ {WIDTH{bus.sub}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         c_out_q     <= 1'b0;
         overflow_q  <= 1'b0;
         cnt         <= '0;
         carry_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  in_ready_q <= 1'b0;
                  carry_q    <= bus.sub;
                  cnt        <= '0;
                  state      <= RUN;
               end
            end
            RUN: begin
               result_q[16*cnt +: 16] <= add_p0[15:0];
               carry_q                <= add_p0[16];
               cnt                    <= cnt + CNT_W'(1);
               if (cnt == LAST_SLICE) begin
                  c_out_q     <= add_p0[16];
                  // Signed overflow uses the already-inverted B operand.
                  overflow_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                 (add_p0[15] != a_q[WIDTH-1]);
                  out_valid_q <= 1'b1;
                  cnt         <= '0;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mp_add_sequencer.sv
// Bench for mp_add_sequencer: directed plan cases plus randomized ops against an
// arithmetic reference model, checked every cycle the result is valid.
module tb_mp_add_sequencer;
   localparam int WIDTH = 64;
   localparam int NS    = WIDTH / 16;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   longint cyc = 0;
   int     total = 0;
   int     bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mp_add_sequencer_if #(.WIDTH(WIDTH)) bus ();
   mp_add_sequencer #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      logic [WIDTH-1:0] r;
      logic             c;
      logic             v;
      longint           t;
   } exp_t;

   exp_t   q[$];
   longint acc_t[$];
   bit     seen = 1'b0;

   task automatic check(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic sub, input longint t);
      exp_t e;
      logic signed [WIDTH:0] sa, sb, s;
      logic [WIDTH:0] u;
      sa = {a[WIDTH-1], a};
      sb = {b[WIDTH-1], b};
      if (sub) begin
         e.r = a - b;
         e.c = (a >= b);
         s   = sa - sb;
      end else begin
         u   = {1'b0, a} + {1'b0, b};
         e.r = u[WIDTH-1:0];
         e.c = u[WIDTH];
         s   = sa + sb;
      end
      e.v = (s[WIDTH] != s[WIDTH-1]);
      e.t = t;
      return e;
   endfunction

   // Compare process: every valid cycle is checked against the model's head entry.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         seen = 1'b0;
         check("rst_in_ready", {63'b0, bus.in_ready}, 64'd0);
         check("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
         check("rst_result", bus.result, 64'd0);
      end else begin
         if (bus.in_valid && bus.in_ready) begin
            q.push_back(model(bus.a, bus.b, bus.sub, cyc));
            acc_t.push_back(cyc);
         end
         if (bus.out_valid) begin
            if (q.size() == 0) begin
               check("spurious_out_valid", 64'd1, 64'd0);
            end else begin
               check("m_result", bus.result, q[0].r);
               check("m_c_out", {63'b0, bus.c_out}, {63'b0, q[0].c});
               check("m_overflow", {63'b0, bus.overflow}, {63'b0, q[0].v});
               check("m_in_ready_low", {63'b0, bus.in_ready}, 64'd0);
               if (!seen) check("m_latency", 64'(cyc - q[0].t), 64'(NS + 1));
               seen = 1'b1;
               if (bus.out_ready) begin
                  void'(q.pop_front());
                  seen = 1'b0;
               end
            end
         end
      end
   end

   task automatic do_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
      bit ok = 1'b0;
      bus.a = a;
      bus.b = b;
      bus.sub = sub;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic wait_out();
      bit ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("out_valid_timeout", 64'd0, 64'd1);
   endtask

   task automatic lit_op(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sub, input logic [WIDTH-1:0] er, input logic ec,
                         input logic ev);
      do_req(a, b, sub);
      wait_out();
      check({nm, "_result"}, bus.result, er);
      check({nm, "_c_out"}, {63'b0, bus.c_out}, {63'b0, ec});
      check({nm, "_overflow"}, {63'b0, bus.overflow}, {63'b0, ev});
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] edges [6];
      logic [WIDTH-1:0] ra, rb;
      edges[0] = '0;
      edges[1] = '1;
      edges[2] = 64'h8000_0000_0000_0000;
      edges[3] = 64'h7FFF_FFFF_FFFF_FFFF;
      edges[4] = 64'h0000_0000_FFFF_FFFF;
      edges[5] = 64'h0000_FFFF_0000_FFFF;

      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.sub = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_before_edge", {63'b0, bus.in_ready}, 64'd0);
      @(negedge clk);
      check("in_ready_after_edge", {63'b0, bus.in_ready}, 64'd1);
      @(posedge clk);
      #1;

      lit_op("ripple", '1, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
      lit_op("borrow", 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
      lit_op("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1);
      lit_op("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b1,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

      // Backpressure
      bus.out_ready = 1'b0;
      do_req(64'd3, 64'd4, 1'b0);
      wait_out();
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", {63'b0, bus.out_valid}, 64'd1);
         check("bp_result", bus.result, 64'd7);
         check("bp_in_ready", {63'b0, bus.in_ready}, 64'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_valid", {63'b0, bus.out_valid}, 64'd0);
      check("bp_release_ready", {63'b0, bus.in_ready}, 64'd1);

      // Back-to-back with in_valid held high
      acc_t.delete();
      bus.a = 64'd10;
      bus.b = 64'd20;
      bus.sub = 1'b0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 50 && acc_t.size() < 1; i++) @(negedge clk);
      @(posedge clk);
      #1;
      bus.a = 64'd100;
      bus.b = 64'd1;
      bus.sub = 1'b1;
      wait_out();
      check("b2b_first", bus.result, 64'd30);
      @(posedge clk);
      #1;
      for (int i = 0; i < 50 && acc_t.size() < 2; i++) @(negedge clk);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      wait_out();
      check("b2b_second", bus.result, 64'd99);
      if (acc_t.size() >= 2) check("b2b_interval", 64'(acc_t[1] - acc_t[0]), 64'(NS + 2));
      else check("b2b_accepts", 64'(acc_t.size()), 64'd2);
      @(posedge clk);
      #1;

      // Reset mid-RUN
      do_req(64'd5, 64'd6, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_out_valid", {63'b0, bus.out_valid}, 64'd0);
      check("abort_result", bus.result, 64'd0);
      check("abort_in_ready", {63'b0, bus.in_ready}, 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      lit_op("post_rst", 64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 1'b0);

      // Randomized ops with random backpressure, checked by the model
      for (int n = 0; n < 60; n++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) ra = edges[$urandom_range(0, 5)];
         if ($urandom_range(0, 3) == 0) rb = edges[$urandom_range(0, 5)];
         bus.out_ready = 1'b0;
         do_req(ra, rb, 1'($urandom_range(0, 1)));
         repeat (NS + $urandom_range(0, 3)) @(posedge clk);
         #1 bus.out_ready = 1'b1;
         wait_out();
         @(posedge clk);
         #1;
      end
      repeat (2) @(posedge clk);
      check("queue_drained", 64'(q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
